// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU encodings: the R-type opcode, the supported funct codes and the ALU Sel codes.
// decode() maps an instruction to its Sel code and reports whether it is a supported R-type op.
package alu_issue_stage_pkg;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;

  localparam logic [3:0] SEL_AND    = 4'b0000;
  localparam logic [3:0] SEL_OR     = 4'b0001;
  localparam logic [3:0] SEL_ADD    = 4'b0010;
  localparam logic [3:0] SEL_SUB    = 4'b0110;
  localparam logic [3:0] SEL_SLT    = 4'b0111;
  localparam logic [3:0] SEL_NOR    = 4'b1100;

  typedef struct packed {
    logic       ok;
    logic [3:0] sel;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d.ok  = 1'b0;
    d.sel = SEL_AND;
    if (opcode == OPC_RTYPE) begin
      d.ok = 1'b1;
      case (funct)
        FUNCT_ADD: d.sel = SEL_ADD;
        FUNCT_SUB: d.sel = SEL_SUB;
        FUNCT_AND: d.sel = SEL_AND;
        FUNCT_OR:  d.sel = SEL_OR;
        FUNCT_SLT: d.sel = SEL_SLT;
        FUNCT_NOR: d.sel = SEL_NOR;
        default:   d.ok  = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// Architectural register file: two combinational read ports, one write port on the rising edge.
// Register 0 reads as zero and ignores writes.
module alu_issue_stage_reg_file #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the ALU: reads rs/rt with write-back forwarding, decodes funct to Sel,
// and holds the operation in a valid/ready output register (1-cycle latency, 1 op/cycle).
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] OP1,
  output logic [XLEN-1:0] OP2,
  output logic [3:0]      Sel,
  output logic [AW-1:0]   rd,
  output logic            illegal
);

  logic [AW-1:0]   rs_addr, rt_addr, rd_addr;
  logic [XLEN-1:0] rs_val, rt_val, op1_next, op2_next;
  logic [4:0]      unused_shamt;
  logic            accept, wb_live;
  dec_t            dec;

  assign rs_addr      = instr[21 +: AW];
  assign rt_addr      = instr[16 +: AW];
  assign rd_addr      = instr[11 +: AW];
  assign unused_shamt = instr[10:6];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign dec      = decode(instr[31:26], instr[5:0]);

  alu_issue_stage_reg_file #(
    .NREGS (NREGS),
    .XLEN  (XLEN),
    .AW    (AW)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs_addr),
    .rdata_a (rs_val),
    .raddr_b (rt_addr),
    .rdata_b (rt_val),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // A write landing on this same edge must be seen by the instruction issuing now.
  assign wb_live  = wb_en && (wb_addr != '0);
  assign op1_next = (wb_live && (wb_addr == rs_addr)) ? wb_data : rs_val;
  assign op2_next = (wb_live && (wb_addr == rt_addr)) ? wb_data : rt_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      OP1       <= '0;
      OP2       <= '0;
      Sel       <= '0;
      rd        <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal <= accept && !dec.ok;
      if (accept && dec.ok) begin
        out_valid <= 1'b1;
        OP1       <= op1_next;
        OP2       <= op2_next;
        Sel       <= dec.sel;
        rd        <= rd_addr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: scoreboard of expected issued operations.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] OP1, OP2;
  logic [3:0]  Sel;
  logic [4:0]  rd;
  logic        illegal;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  sel;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OP1       (OP1),
    .OP2       (OP2),
    .Sel       (Sel),
    .rd        (rd),
    .illegal   (illegal)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs_i, input logic [4:0] rt_i,
                                        input logic [4:0] rd_i, input logic [5:0] fn);
    return {6'b000000, rs_i, rt_i, rd_i, 5'd0, fn};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] s, input logic [4:0] r);
    exp_t x;
    x.op1 = a; x.op2 = b; x.sel = s; x.rd = r;
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, OP1, OP2, Sel, rd, illegal} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b op1=%h op2=%h sel=%b rd=%0d ill=%b, want all zero",
               out_valid, OP1, OP2, Sel, rd, illegal);
    end
    rst = 1'b0;
    tick();
    // Load a register and hold an op, then reset mid-cycle.
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00221820;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || OP1 !== 32'd5) begin
      errors++;
      $display("FAIL pre_reset_hold: got v=%b op1=%h, want v=1 op1=5", out_valid, OP1);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, OP1, OP2, Sel, rd, illegal} !== '0) begin
      errors++;
      $display("FAIL midstream_reset: got v=%b op1=%h op2=%h sel=%b rd=%0d ill=%b, want all zero",
               out_valid, OP1, OP2, Sel, rd, illegal);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    // Registers must have been cleared: add r3,r1,r2 reads zeros.
    in_valid = 1'b1; instr = 32'h00221820;
    exp_q.push_back(mk(32'd0, 32'd0, 4'b0010, 5'd3));
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL regs_cleared_valid: got v=%b, want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({OP1, OP2, Sel, rd} !== {e.op1, e.op2, e.sel, e.rd}) begin
        errors++;
        $display("FAIL regs_cleared: got %h %h %b %0d, want %h %h %b %0d",
                 OP1, OP2, Sel, rd, e.op1, e.op2, e.sel, e.rd);
      end
    end
    tick();
  endtask

  task automatic test_add;
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00221820;
    exp_q.push_back(mk(32'd5, 32'd3, 4'b0010, 5'd3));
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL add_valid: got v=%b, want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({OP1, OP2, Sel, rd} !== {e.op1, e.op2, e.sel, e.rd}) begin
        errors++;
        $display("FAIL add_fields: got %h %h %b %0d, want %h %h %b %0d",
                 OP1, OP2, Sel, rd, e.op1, e.op2, e.sel, e.rd);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b1; in_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd5, 6'b100100);
    exp_q.push_back(mk(32'd5, 32'd3, 4'b0000, 5'd5));
    tick();
    out_ready = 1'b0; instr = rtype(5'd2, 5'd1, 5'd6, 6'b100101);
    exp_q.push_back(mk(32'd3, 32'd5, 4'b0001, 5'd6));
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got in_ready=%b v=%b, want 0 1", i, in_ready, out_valid);
      end
      checks++;
      if ({OP1, OP2, Sel, rd} !== {exp_q[0].op1, exp_q[0].op2, exp_q[0].sel, exp_q[0].rd}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h %h %b %0d, want %h %h %b %0d", i,
                 OP1, OP2, Sel, rd, exp_q[0].op1, exp_q[0].op2, exp_q[0].sel, exp_q[0].rd);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL stall_next_valid: got v=%b, want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({OP1, OP2, Sel, rd} !== {e.op1, e.op2, e.sel, e.rd}) begin
        errors++;
        $display("FAIL stall_next_fields: got %h %h %b %0d, want %h %h %b %0d",
                 OP1, OP2, Sel, rd, e.op1, e.op2, e.sel, e.rd);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_forwarding;
    logic [31:0] instrs [4];
    logic        wbe    [4];
    logic [4:0]  wba    [4];
    logic [31:0] wbd    [4];
    instrs[0] = rtype(5'd1, 5'd0, 5'd7, 6'b100010); wbe[0] = 1; wba[0] = 5'd1; wbd[0] = 32'hDEADBEEF;
    instrs[1] = rtype(5'd0, 5'd1, 5'd8, 6'b100000); wbe[0+1] = 1; wba[1] = 5'd0; wbd[1] = 32'h1234;
    instrs[2] = rtype(5'd0, 5'd2, 5'd9, 6'b101010); wbe[2] = 1; wba[2] = 5'd2; wbd[2] = 32'h55;
    instrs[3] = rtype(5'd1, 5'd2, 5'd10, 6'b100111); wbe[3] = 0; wba[3] = 5'd0; wbd[3] = 32'h0;
    exp_q.push_back(mk(32'hDEADBEEF, 32'd0, 4'b0110, 5'd7));
    exp_q.push_back(mk(32'd0, 32'hDEADBEEF, 4'b0010, 5'd8));
    exp_q.push_back(mk(32'd0, 32'h55, 4'b0111, 5'd9));
    exp_q.push_back(mk(32'hDEADBEEF, 32'h55, 4'b1100, 5'd10));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = instrs[i];
      wb_en = wbe[i]; wb_addr = wba[i]; wb_data = wbd[i];
      tick();
      in_valid = 1'b0; wb_en = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL fwd_valid[%0d]: got v=%b, want 1", i, out_valid);
      end else begin
        e = exp_q.pop_front();
        if ({OP1, OP2, Sel, rd} !== {e.op1, e.op2, e.sel, e.rd}) begin
          errors++;
          $display("FAIL fwd_fields[%0d]: got %h %h %b %0d, want %h %h %b %0d", i,
                   OP1, OP2, Sel, rd, e.op1, e.op2, e.sel, e.rd);
        end
      end
    end
    tick();
  endtask

  task automatic test_illegal;
    logic [31:0] bad [2];
    bad[0] = {6'b100011, 5'd1, 5'd2, 16'h0004};
    bad[1] = rtype(5'd1, 5'd2, 5'd3, 6'b000000);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; instr = bad[i];
      tick();
      in_valid = 1'b0;
      checks++;
      if (illegal !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse[%0d]: got ill=%b v=%b, want 1 0", i, illegal, out_valid);
      end
      tick();
      checks++;
      if (illegal !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_clear[%0d]: got ill=%b v=%b, want 0 0", i, illegal, out_valid);
      end
    end
  endtask

  task automatic test_capture;
    out_ready = 1'b1; in_valid = 1'b1; instr = rtype(5'd1, 5'd2, 5'd4, 6'b100101);
    exp_q.push_back(mk(32'hDEADBEEF, 32'h55, 4'b0001, 5'd4));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL capture_valid: got v=%b, want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      if ({OP1, OP2, Sel, rd} !== {e.op1, e.op2, e.sel, e.rd}) begin
        errors++;
        $display("FAIL capture_fields: got %h %h %b %0d, want %h %h %b %0d",
                 OP1, OP2, Sel, rd, e.op1, e.op2, e.sel, e.rd);
      end
    end
    wb(5'd1, 32'd7);
    tick();
    checks++;
    if (OP1 !== 32'hDEADBEEF || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL capture_hold: got op1=%h v=%b, want deadbeef 1", OP1, out_valid);
    end
    out_ready = 1'b1; in_valid = 1'b1; instr = rtype(5'd1, 5'd0, 5'd11, 6'b100000);
    exp_q.push_back(mk(32'd7, 32'd0, 4'b0010, 5'd11));
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL capture_next_valid: got v=%b, want 1", out_valid);
    end else begin
      e = exp_q.pop_front();
      if ({OP1, OP2, Sel, rd} !== {e.op1, e.op2, e.sel, e.rd}) begin
        errors++;
        $display("FAIL capture_next: got %h %h %b %0d, want %h %h %b %0d",
                 OP1, OP2, Sel, rd, e.op1, e.op2, e.sel, e.rd);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_forwarding();
    test_illegal();
    test_capture();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
